// File: rtl/des_iter_engine.sv
// des_iter_engine
//   Iterative DES (FIPS 46-3) encrypt/decrypt engine. It holds one 64-bit
//   block at a time and computes ROUNDS_PER_CYCLE Feistel rounds per clock.
//   Subkeys come from the C/D key halves, which are rotated as the rounds
//   proceed.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   din/key/decrypt are valid
//   in_ready   engine can accept a block (IDLE, or DONE while out_ready=1)
//   din        plaintext/ciphertext block, bit 63 = DES bit 1
//   key        64-bit DES key; the parity bits are ignored
//   decrypt    0 = encrypt, 1 = decrypt; sampled when the block is accepted
//   out_valid  dout holds a finished result
//   out_ready  sink accepts dout
//   dout       result block
//   busy       rounds in progress

module des_iter_engine #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] din,
  input  logic [63:0] key,
  input  logic        decrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] dout,
  output logic        busy
);

  generate
    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
          ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rounds_per_cycle
      $error("des_iter_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  typedef struct packed {
    logic [31:0] l;
    logic [31:0] r;
    logic [27:0] c;
    logic [27:0] d;
  } round_t;

  // The permutation tables use DES bit numbering: entry i names the source
  // bit of output bit i+1, where bit 1 is the MSB.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int IPINV_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // S1..S8 back to back, each as four rows of sixteen columns, so the entry
  // index is {box, row, column}.
  localparam int SBOX_T [512] = '{
    14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
     0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
     4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
    15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13,
    15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
     3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
     0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
    13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9,
    10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
    13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
    13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
     1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12,
     7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
    13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
    10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
     3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14,
     2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
    14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
     4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
    11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3,
    12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
    10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
     9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
     4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13,
     4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
    13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
     1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
     6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12,
    13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
     1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
     7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
     2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11};

  // Each permutation shifts output bits in MSB first. DES bit b of an N-bit
  // word is vector index N-b.
  function automatic logic [63:0] permIp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y = {y[62:0], x[6'(64 - IP_T[i])]};
    return y;
  endfunction

  function automatic logic [63:0] permIpInv(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y = {y[62:0], x[6'(64 - IPINV_T[i])]};
    return y;
  endfunction

  function automatic logic [55:0] permPc1(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y = {y[54:0], x[6'(64 - PC1_T[i])]};
    return y;
  endfunction

  function automatic logic [47:0] permPc2(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y = {y[46:0], x[6'(56 - PC2_T[i])]};
    return y;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] subkey);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] y;
    logic [5:0]  six;
    logic [8:0]  idx;
    x = '0;
    for (int i = 0; i < 48; i++) x = {x[46:0], r[5'(32 - E_T[i])]};
    x = x ^ subkey;
    s = '0;
    for (int b = 0; b < 8; b++) begin
      six = 6'(x >> (42 - 6 * b));
      // The outer bits of each 6-bit group select the row, the inner four the column
      idx = {3'(b), six[5], six[0], six[4:1]};
      s = {s[27:0], 4'(SBOX_T[idx])};
    end
    y = '0;
    for (int i = 0; i < 32; i++) y = {y[30:0], s[5'(32 - P_T[i])]};
    return y;
  endfunction

  // One Feistel round numbered n (1..16). Encrypt rotates C/D left before
  // deriving Kn. Decrypt walks the schedule backwards: round 1 uses the
  // unrotated halves, which equal C16/D16. Later rounds rotate right.
  function automatic round_t desRound(input round_t st, input logic [4:0] n, input logic dec);
    round_t      nx;
    logic        one;
    logic [47:0] subkey;
    nx = st;
    if (!dec) begin
      one = (n == 5'd1) || (n == 5'd2) || (n == 5'd9) || (n == 5'd16);
      nx.c = one ? {st.c[26:0], st.c[27]} : {st.c[25:0], st.c[27:26]};
      nx.d = one ? {st.d[26:0], st.d[27]} : {st.d[25:0], st.d[27:26]};
    end else begin
      one = (n == 5'd2) || (n == 5'd9) || (n == 5'd16);
      if (n != 5'd1) begin
        nx.c = one ? {st.c[0], st.c[27:1]} : {st.c[1:0], st.c[27:2]};
        nx.d = one ? {st.d[0], st.d[27:1]} : {st.d[1:0], st.d[27:2]};
      end
    end
    subkey = permPc2({nx.c, nx.d});
    nx.l = st.r;
    nx.r = st.l ^ feistel(st.r, subkey);
    return nx;
  endfunction

  state_t      r_state;
  state_t      w_stateNext;
  logic [31:0] r_l;
  logic [31:0] r_r;
  logic [27:0] r_c;
  logic [27:0] r_d;
  logic [4:0]  r_round;
  logic        r_decrypt;
  logic [63:0] r_dout;
  round_t      w_chain;
  logic [4:0]  w_roundNext;
  logic        w_lastStep;
  logic        w_accept;

  // Chain ROUNDS_PER_CYCLE rounds combinationally from the registered state
  always_comb begin
    w_chain = '{l: r_l, r: r_r, c: r_c, d: r_d};
    for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
      w_chain = desRound(w_chain, r_round + 5'(k) + 5'd1, r_decrypt);
    end
  end

  assign w_roundNext = r_round + 5'(ROUNDS_PER_CYCLE);
  assign w_lastStep  = (r_state == ROUND) && (w_roundNext == 5'd16);
  assign w_accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  // In DONE, in_ready follows out_ready, so draining a result and accepting
  // the next block happen on the same edge.
  always_comb begin
    w_stateNext = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_stateNext = ROUND;
      end
      ROUND: begin
        busy = 1'b1;
        if (w_lastStep) w_stateNext = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) w_stateNext = in_valid ? ROUND : IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Datapath: load on accept, advance while in ROUND, and capture the output
  // with the final L/R swap on the edge that completes round 16.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_l       <= '0;
      r_r       <= '0;
      r_c       <= '0;
      r_d       <= '0;
      r_round   <= '0;
      r_decrypt <= 1'b0;
      r_dout    <= '0;
    end else if (w_accept) begin
      {r_l, r_r} <= permIp(din);
      {r_c, r_d} <= permPc1(key);
      r_decrypt  <= decrypt;
      r_round    <= '0;
    end else if (r_state == ROUND) begin
      r_l     <= w_chain.l;
      r_r     <= w_chain.r;
      r_c     <= w_chain.c;
      r_d     <= w_chain.d;
      r_round <= w_roundNext;
      if (w_lastStep) r_dout <= permIpInv({w_chain.r, w_chain.l});
    end
  end

  assign dout = r_dout;

endmodule

// File: tb/tb_des_iter_engine.sv
// tb_des_iter_engine
//   Directed bench for des_iter_engine. The main instance uses one round per
//   clock. Four more instances, with 2, 4, 8 and 16 rounds per clock, share
//   the data inputs and are exercised together with the main instance at the
//   start of the run.

module tb_des_iter_engine;

  localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
  localparam logic [63:0] KEY2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] PT2  = 64'h8787878787878787;
  localparam logic [63:0] CT2  = 64'h0000000000000000;

  localparam int SWEEP_RPC [4] = '{2, 4, 8, 16};

  localparam logic [63:0] BTB_IN  [4] = '{PT1, CT1, PT2, CT2};
  localparam logic [63:0] BTB_KEY [4] = '{KEY1, KEY1, KEY2, KEY2};
  localparam logic        BTB_DEC [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [63:0] BTB_EXP [4] = '{CT1, PT1, CT2, PT2};

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] din;
  logic [63:0] key;
  logic        decrypt;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] dout;
  logic        busy;

  logic        sweepValid;
  logic        sweepReady;
  logic        sweepInReady [4];
  logic        sweepOutValid [4];
  logic        sweepBusy [4];
  logic [63:0] sweepDout [4];

  int          compareCount = 0;
  int          failCount = 0;
  int          mainLat;
  logic [63:0] mainRes;
  int          sweepLat [4];
  logic [63:0] sweepRes [4];
  int          staleSeen;
  int          edgeCount;

  des_iter_engine #(.ROUNDS_PER_CYCLE(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .key       (key),
    .decrypt   (decrypt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .busy      (busy)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    des_iter_engine #(.ROUNDS_PER_CYCLE(SWEEP_RPC[g])) u_sweep (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (sweepValid),
      .in_ready  (sweepInReady[g]),
      .din       (din),
      .key       (key),
      .decrypt   (decrypt),
      .out_valid (sweepOutValid[g]),
      .out_ready (sweepReady),
      .dout      (sweepDout[g]),
      .busy      (sweepBusy[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // Outputs are sampled 2 time units after each rising edge
  task automatic stepClk();
    @(posedge clk);
    #2;
  endtask

  task automatic waitReady(input string tag);
    int n = 0;
    #1;
    while (in_ready !== 1'b1 && n < 40) begin
      stepClk();
      n++;
    end
    if (in_ready !== 1'b1) checkBit({tag, " ready timeout"}, in_ready, 1'b1);
  endtask

  // Presents a block and returns just after its accept edge. The inputs are
  // then scrambled so that a later change cannot leak into the result.
  task automatic applyStimulus(input string tag, input logic [63:0] d, input logic [63:0] k,
                               input logic dec);
    din      = d;
    key      = k;
    decrypt  = dec;
    in_valid = 1'b1;
    waitReady(tag);
    stepClk();
    in_valid = 1'b0;
    din      = ~d;
    key      = ~k;
    decrypt  = ~dec;
  endtask

  task automatic waitResult(input string tag, input logic [63:0] expected, input int lat);
    int n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      stepClk();
      n++;
    end
    checkOutput({tag, " latency"}, 64'(n), 64'(lat));
    checkOutput({tag, " dout"}, dout, expected);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    sweepValid = 1'b0;
    sweepReady = 1'b1;
    out_ready  = 1'b1;
    din        = '0;
    key        = '0;
    decrypt    = 1'b0;
    mainLat    = 0;
    mainRes    = '0;
    for (int g = 0; g < 4; g++) begin
      sweepLat[g] = 0;
      sweepRes[g] = '0;
    end

    #22;
    $display("[TB] reset state");
    checkBit("reset in_ready", in_ready, 1'b1);
    checkBit("reset out_valid", out_valid, 1'b0);
    checkBit("reset busy", busy, 1'b0);
    checkOutput("reset dout", dout, 64'h0);
    #1 rst_n = 1'b1;
    stepClk();

    $display("[TB] parameter sweep, encrypt vector 1");
    din        = PT1;
    key        = KEY1;
    decrypt    = 1'b0;
    in_valid   = 1'b1;
    sweepValid = 1'b1;
    #1;
    checkBit("sweep main ready", in_ready, 1'b1);
    for (int g = 0; g < 4; g++) checkBit($sformatf("sweep rpc%0d ready", SWEEP_RPC[g]), sweepInReady[g], 1'b1);
    stepClk();
    in_valid   = 1'b0;
    sweepValid = 1'b0;
    din        = ~PT1;
    for (int e = 1; e <= 20; e++) begin
      stepClk();
      if (out_valid === 1'b1 && mainLat == 0) begin
        mainLat = e;
        mainRes = dout;
      end
      for (int g = 0; g < 4; g++) begin
        if (sweepOutValid[g] === 1'b1 && sweepLat[g] == 0) begin
          sweepLat[g] = e;
          sweepRes[g] = sweepDout[g];
        end
      end
    end
    checkOutput("sweep rpc1 latency", 64'(mainLat), 64'd16);
    checkOutput("sweep rpc1 dout", mainRes, CT1);
    for (int g = 0; g < 4; g++) begin
      checkOutput($sformatf("sweep rpc%0d latency", SWEEP_RPC[g]), 64'(sweepLat[g]), 64'(16 / SWEEP_RPC[g]));
      checkOutput($sformatf("sweep rpc%0d dout", SWEEP_RPC[g]), sweepRes[g], CT1);
    end

    $display("[TB] decrypt vector 1");
    applyStimulus("dec1", CT1, KEY1, 1'b1);
    checkBit("dec1 busy", busy, 1'b1);
    waitResult("dec1", PT1, 16);

    $display("[TB] encrypt vector 2");
    applyStimulus("enc2", PT2, KEY2, 1'b0);
    waitResult("enc2", CT2, 16);
    stepClk();

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus("bp", PT1, KEY1, 1'b0);
    waitResult("bp", CT1, 16);
    din      = CT1;
    key      = KEY1;
    decrypt  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checkBit($sformatf("bp hold %0d out_valid", i), out_valid, 1'b1);
      checkBit($sformatf("bp hold %0d in_ready", i), in_ready, 1'b0);
      checkOutput($sformatf("bp hold %0d dout", i), dout, CT1);
      stepClk();
    end
    out_ready = 1'b1;
    #1;
    checkBit("bp release in_ready", in_ready, 1'b1);
    stepClk();
    checkBit("bp drained out_valid", out_valid, 1'b0);
    checkBit("bp pending accepted busy", busy, 1'b1);
    in_valid = 1'b0;
    din      = '0;
    waitResult("bp pending", PT1, 16);

    $display("[TB] back-to-back blocks");
    for (int i = 0; i < 4; i++) begin
      din       = BTB_IN[i];
      key       = BTB_KEY[i];
      decrypt   = BTB_DEC[i];
      in_valid  = 1'b1;
      edgeCount = 0;
      #1;
      while (in_ready !== 1'b1 && edgeCount < 40) begin
        stepClk();
        edgeCount++;
      end
      if (i > 0) begin
        checkOutput($sformatf("btb%0d latency", i - 1), 64'(edgeCount), 64'd16);
        checkBit($sformatf("btb%0d out_valid", i - 1), out_valid, 1'b1);
        checkOutput($sformatf("btb%0d dout", i - 1), dout, BTB_EXP[i - 1]);
      end
      stepClk();
    end
    in_valid = 1'b0;
    waitResult("btb3", BTB_EXP[3], 16);

    $display("[TB] reset during round 7");
    applyStimulus("rst blk", PT1, KEY1, 1'b0);
    repeat (6) stepClk();
    rst_n = 1'b0;
    #1;
    checkBit("midrst out_valid", out_valid, 1'b0);
    checkBit("midrst in_ready", in_ready, 1'b1);
    checkBit("midrst busy", busy, 1'b0);
    checkOutput("midrst dout", dout, 64'h0);
    #3 rst_n = 1'b1;
    staleSeen = 0;
    repeat (20) begin
      stepClk();
      if (out_valid === 1'b1) staleSeen++;
    end
    checkOutput("midrst no stale out_valid", 64'(staleSeen), 64'd0);
    applyStimulus("post rst", PT2, KEY2, 1'b0);
    waitResult("post rst", CT2, 16);
    stepClk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
